bsram_bist_ctrl: RTL

- Built-in self-test controller driving the 2048x8 true-dual-port BSRAM macro.
- Writes a deterministic pattern through port A and reads it back through port B. Read port is in pipelined read mode with a synchronous reset.
- Compares each readback against the expected data, counts mismatches and latches the first failing address.
- Sits directly upstream of the BSRAM: it owns every RAM control, address and data input and consumes doutb.

---
 rtl/bsram_bist_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/bsram_bist_ctrl.sv
// March-style BIST sequencer for the 2048x8 true-dual-port BSRAM: writes an
// address-seeded pattern on port A, reads it back on port B, then repeats inverted.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start; results of the last run held
// S_WRITE | one port-A write per cycle, address 0..DEPTH-1
// S_READ  | one port-B read per cycle, address 0..DEPTH-1
// S_DRAIN | RD_LAT cycles letting the read pipeline empty
// S_DONE  | single cycle: done pulse, pass published
module bsram_bist_ctrl #(
    parameter int                ADDR_W = 11,
    parameter int                DATA_W = 8,
    parameter logic [DATA_W-1:0] SEED   = 8'hA5,
    parameter int                RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              ram_reset,
    output logic              ram_cea,
    output logic              ram_ocea,
    output logic              ram_wrea,
    output logic [ADDR_W-1:0] ram_ada,
    output logic [DATA_W-1:0] ram_dina,
    output logic              ram_ceb,
    output logic              ram_oceb,
    output logic              ram_wreb,
    output logic [ADDR_W-1:0] ram_adb,
    input  logic [DATA_W-1:0] ram_doutb
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam int                DCNT_W    = $clog2(RD_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   addr;
    logic                phase;
    logic [DCNT_W-1:0]   drain_cnt;

    logic                dl_valid [RD_LAT];
    logic [DATA_W-1:0]   dl_exp   [RD_LAT];
    logic [ADDR_W-1:0]   dl_addr  [RD_LAT];

    logic [15:0]         err_cnt_nxt;
    logic [ADDR_W-1:0]   first_err_nxt;

    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a, input logic ph);
        logic [DATA_W-1:0] p;
        p = DATA_W'(a) ^ SEED;
        return ph ? ~p : p;
    endfunction

    assign ram_reset = ~rst_n;
    assign ram_ocea  = 1'b0;
    assign ram_wreb  = 1'b0;

    // Each stage tracks what the RAM pipeline holds for the matching read cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                dl_valid[i] <= 1'b0;
                dl_exp[i]   <= '0;
                dl_addr[i]  <= '0;
            end
        end else begin
            dl_valid[0] <= ram_ceb;
            dl_exp[0]   <= pattern(ram_adb, phase);
            dl_addr[0]  <= ram_adb;
            for (int i = 1; i < RD_LAT; i++) begin
                dl_valid[i] <= dl_valid[i-1];
                dl_exp[i]   <= dl_exp[i-1];
                dl_addr[i]  <= dl_addr[i-1];
            end
        end
    end

    always_comb begin
        err_cnt_nxt   = err_cnt;
        first_err_nxt = first_err_addr;
        if (dl_valid[RD_LAT-1] && (ram_doutb != dl_exp[RD_LAT-1])) begin
            if (err_cnt != 16'hFFFF) err_cnt_nxt = err_cnt + 16'd1;
            if (err_cnt == 16'd0)    first_err_nxt = dl_addr[RD_LAT-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            addr           <= '0;
            phase          <= 1'b0;
            drain_cnt      <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            ram_cea        <= 1'b0;
            ram_wrea       <= 1'b0;
            ram_ada        <= '0;
            ram_dina       <= '0;
            ram_ceb        <= 1'b0;
            ram_oceb       <= 1'b0;
            ram_adb        <= '0;
        end else begin
            done           <= 1'b0;
            err_cnt        <= err_cnt_nxt;
            first_err_addr <= first_err_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state          <= S_WRITE;
                        err_cnt        <= '0;
                        first_err_addr <= '0;
                        pass           <= 1'b0;
                        phase          <= 1'b0;
                        addr           <= '0;
                        busy           <= 1'b1;
                        ram_cea        <= 1'b1;
                        ram_wrea       <= 1'b1;
                        ram_ada        <= '0;
                        ram_dina       <= pattern('0, 1'b0);
                    end
                end
                S_WRITE: begin
                    if (addr == LAST_ADDR) begin
                        state    <= S_READ;
                        addr     <= '0;
                        ram_cea  <= 1'b0;
                        ram_wrea <= 1'b0;
                        ram_ceb  <= 1'b1;
                        ram_oceb <= 1'b1;
                        ram_adb  <= '0;
                    end else begin
                        addr     <= addr + ADDR_W'(1);
                        ram_ada  <= addr + ADDR_W'(1);
                        ram_dina <= pattern(addr + ADDR_W'(1), phase);
                    end
                end
                S_READ: begin
                    if (addr == LAST_ADDR) begin
                        state     <= S_DRAIN;
                        addr      <= '0;
                        ram_ceb   <= 1'b0;
                        drain_cnt <= DCNT_W'(RD_LAT - 1);
                    end else begin
                        addr    <= addr + ADDR_W'(1);
                        ram_adb <= addr + ADDR_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == '0) begin
                        ram_oceb <= 1'b0;
                        if (!phase) begin
                            state    <= S_WRITE;
                            phase    <= 1'b1;
                            addr     <= '0;
                            ram_cea  <= 1'b1;
                            ram_wrea <= 1'b1;
                            ram_ada  <= '0;
                            ram_dina <= pattern('0, 1'b1);
                        end else begin
                            // The final compare lands this cycle, so pass uses the updated count.
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_cnt_nxt == 16'd0);
                        end
                    end else begin
                        drain_cnt <= drain_cnt - DCNT_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
